// File: rtl/sme_multi_match.sv
// sme_multi_match: string/pattern matcher scanning one head per cycle with wildcard, anchors, nocase and find-all
module sme_multi_match #(
    parameter int CHAR_W      = 8,
    parameter int STR_MAX_LEN = 32,
    parameter int PAT_MAX_LEN = 8,
    parameter int IDX_W       = $clog2(STR_MAX_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    input  logic              nocase,
    input  logic              find_all,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              last,
    output logic [IDX_W:0]    match_count
);
    localparam int PW = $clog2(PAT_MAX_LEN);
    localparam logic [IDX_W:0] L_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] L_SMAX = (IDX_W+1)'(STR_MAX_LEN);
    localparam logic [IDX_W:0] L_PMAX = (IDX_W+1)'(PAT_MAX_LEN);
    localparam logic [CHAR_W-1:0] C_A   = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0] C_Z   = CHAR_W'(8'h5A);
    localparam logic [CHAR_W-1:0] C_SP  = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] C_DOT = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] C_HAT = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] C_DOL = CHAR_W'(8'h24);

    typedef enum logic [1:0] {S_IDLE, S_LSTR, S_LPAT, S_SRCH} state_t;

    state_t            r_state;
    logic [CHAR_W-1:0] r_s [STR_MAX_LEN];
    logic [CHAR_W-1:0] r_p [PAT_MAX_LEN];
    logic [IDX_W:0]    r_str_len, r_pat_len, r_h, r_count;
    logic              r_anch_h, r_anch_t, r_nocase, r_find_all, r_prev_is;
    logic [IDX_W:0]    w_end, w_pos, w_prev, w_s_idx;
    logic              w_done, w_hit, w_fin, w_s_we, w_p_acc, w_p_we;

    function automatic logic [CHAR_W-1:0] f_fold(input logic [CHAR_W-1:0] c);
        return (r_nocase && c >= C_A && c <= C_Z) ? (c | C_SP) : c;
    endfunction

    // Evaluate the current head against the whole pattern and decode load-side write enables
    always_comb begin
        w_end  = r_h + r_pat_len;
        w_prev = r_h - L_ONE;
        w_done = (r_pat_len == '0) || (w_end > r_str_len);
        w_hit  = !w_done;
        w_pos  = r_h;
        for (int i = 0; i < PAT_MAX_LEN; i++) begin
            w_pos = r_h + (IDX_W+1)'(i);
            if ((IDX_W+1)'(i) < r_pat_len && r_p[i] != C_DOT &&
                f_fold(r_s[w_pos[IDX_W-1:0]]) != f_fold(r_p[i]))
                w_hit = 1'b0;
        end
        if (r_anch_h && r_h != '0 && r_s[w_prev[IDX_W-1:0]] != C_SP) w_hit = 1'b0;
        if (r_anch_t && w_end != r_str_len && r_s[w_end[IDX_W-1:0]] != C_SP) w_hit = 1'b0;
        w_fin   = w_done || (w_hit && !r_find_all);
        w_s_idx = r_prev_is ? r_str_len : '0;
        w_s_we  = r_state != S_SRCH && isstring && w_s_idx < L_SMAX;
        w_p_acc = r_state != S_SRCH && ispattern && !isstring;
        w_p_we  = w_p_acc && chardata != C_HAT && chardata != C_DOL && r_pat_len < L_PMAX;
    end

    // Character storage; contents are qualified by the lengths so no reset is needed
    always_ff @(posedge clk) begin
        if (w_s_we) r_s[w_s_idx[IDX_W-1:0]] <= chardata;
        if (w_p_we) r_p[r_pat_len[PW-1:0]] <= chardata;
    end

    // Control FSM: load string/pattern, scan heads, emit registered result strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_str_len   <= '0;
            r_pat_len   <= '0;
            r_h         <= '0;
            r_count     <= '0;
            r_anch_h    <= 1'b0;
            r_anch_t    <= 1'b0;
            r_nocase    <= 1'b0;
            r_find_all  <= 1'b0;
            r_prev_is   <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            last        <= 1'b0;
            match_count <= '0;
        end else begin
            valid     <= 1'b0;
            r_prev_is <= isstring && r_state != S_SRCH;
            if (w_s_we) r_str_len <= w_s_idx + L_ONE;
            if (w_p_acc) begin
                if (r_state != S_LPAT) begin
                    r_nocase   <= nocase;
                    r_find_all <= find_all;
                end
                if (chardata == C_HAT) r_anch_h <= 1'b1;
                if (chardata == C_DOL) r_anch_t <= 1'b1;
                if (w_p_we) r_pat_len <= r_pat_len + L_ONE;
            end
            case (r_state)
                S_IDLE: r_state <= isstring ? S_LSTR : ispattern ? S_LPAT : S_IDLE;
                S_LSTR: r_state <= w_p_acc ? S_LPAT : S_LSTR;
                S_LPAT: if (!ispattern) begin
                    r_state <= S_SRCH;
                    r_h     <= '0;
                    r_count <= '0;
                end
                default: begin
                    r_h     <= r_h + L_ONE;
                    r_count <= w_hit ? r_count + L_ONE : r_count;
                    if (w_done || w_hit) begin
                        valid       <= 1'b1;
                        match       <= w_hit;
                        last        <= w_fin;
                        match_index <= w_hit ? r_h[IDX_W-1:0] : '0;
                        match_count <= w_done ? r_count : r_count + L_ONE;
                    end
                    if (w_fin) begin
                        r_state    <= S_IDLE;
                        r_pat_len  <= '0;
                        r_anch_h   <= 1'b0;
                        r_anch_t   <= 1'b0;
                        r_nocase   <= 1'b0;
                        r_find_all <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_multi_match.sv
// tb_sme_multi_match: scoreboard bench checking result strobes, their timing and reset behaviour
module tb_sme_multi_match;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] chardata = '0;
    logic       isstring = 1'b0, ispattern = 1'b0, nocase = 1'b0, find_all = 1'b0;
    logic       valid, match, last;
    logic [4:0] match_index;
    logic [5:0] match_count;

    typedef struct {
        int m;
        int idx;
        int lst;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0, pend = 0;

    sme_multi_match dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .nocase(nocase), .find_all(find_all), .valid(valid),
        .match(match), .match_index(match_index), .last(last), .match_count(match_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare every strobe against the head of the scoreboard
    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("match", int'(match), e.m);
                chk("index", int'(match_index), e.idx);
                chk("last", int'(last), e.lst);
                if (e.lst != 0) chk("count", int'(match_count), e.cnt);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push(input int m, input int idx, input int lst, input int cnt, input int off);
        exp_t e;
        e.m = m; e.idx = idx; e.lst = lst; e.cnt = cnt; e.cyc = pend + off;
        q.push_back(e);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            chardata = s[i];
            isstring = 1'b1;
            @(posedge clk); #1;
        end
        isstring = 1'b0;
    endtask

    task automatic load_pat(input string p, input logic nc, input logic fa);
        nocase   = nc;
        find_all = fa;
        for (int i = 0; i < p.len(); i++) begin
            chardata  = p[i];
            ispattern = 1'b1;
            @(posedge clk); #1;
        end
        ispattern = 1'b0;
        nocase    = 1'b0;
        find_all  = 1'b0;
        pend      = cyc;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_match"}, int'(match), 0);
        chk({tag, "_index"}, int'(match_index), 0);
        chk({tag, "_last"}, int'(last), 0);
        chk({tag, "_count"}, int'(match_count), 0);
    endtask

    initial begin
        string long_s;
        #2 reset = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        load_str("hello world");
        load_pat("wor", 1'b0, 1'b0);
        push(1, 6, 1, 1, 8);
        drain();

        load_pat("^o.", 1'b0, 1'b1);
        push(0, 0, 1, 0, 12);
        drain();
        load_pat("o", 1'b0, 1'b1);
        push(1, 4, 0, 1, 6);
        push(1, 7, 0, 2, 9);
        push(0, 0, 1, 2, 13);
        drain();

        load_str("Abc abc");
        load_pat("ABC$", 1'b1, 1'b1);
        push(1, 0, 0, 1, 2);
        push(1, 4, 0, 2, 6);
        push(0, 0, 1, 2, 7);
        drain();
        load_pat("ABC$", 1'b0, 1'b1);
        push(0, 0, 1, 0, 7);
        drain();

        long_s = "";
        for (int i = 0; i < 32; i++) long_s = {long_s, "a"};
        long_s = {long_s, "zzq"};
        load_str(long_s);
        load_pat("zz", 1'b0, 1'b0);
        push(0, 0, 1, 0, 33);
        drain();
        load_pat("aaaaaaaaQQ", 1'b0, 1'b0);
        push(1, 0, 1, 1, 2);
        drain();
        load_pat("a$", 1'b0, 1'b0);
        push(1, 31, 1, 1, 33);
        drain();

        load_pat("^$", 1'b0, 1'b1);
        push(0, 0, 1, 0, 2);
        drain();

        load_str("hello world");
        load_pat("o", 1'b0, 1'b1);
        push(1, 4, 0, 1, 6);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        chk("abort_first_strobe_seen", q.size(), 0);
        q.delete();
        #1 reset = 1'b0;
        #1 chk_zero("abort");
        repeat (4) @(negedge clk);
        chk_zero("abort_hold");
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_after_abort", int'(valid), 0);
        @(posedge clk); #1;

        load_str("hello world");
        load_pat("wor", 1'b0, 1'b0);
        push(1, 6, 1, 1, 8);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
